// File: rtl/sdram_phase_cal.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_phase_cal: searches DCM fine phase and phase90 quadrant for the read |
// | DQS transition, driving the phase detector command port.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sdram_phase_cal #(
  parameter int MAX_STEPS   = 255,
  parameter int SETTLE_CYC  = 16,
  parameter int MEAS_CYC    = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       sclk0,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] ph_err,
  output logic       pre_wcmd,
  output logic [3:0] wd,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] fail_code,
  output logic [8:0] dcm_ofs,
  output logic [1:0] quad
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] c_SETTLE_LAST  = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] c_MEAS_FIRST   = CW'(MEAS_CYC);
  localparam logic [CW-1:0] c_TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    c_MAX_STEPS    = 8'(MAX_STEPS);

  localparam logic [3:0] c_CMD_RESET = 4'hF;
  localparam logic [3:0] c_CMD_NEXTQ = 4'h7;
  localparam logic [3:0] c_CMD_INC   = 4'h1;
  localparam logic [3:0] c_CMD_DEC   = 4'h2;
  localparam logic [3:0] c_CMD_CLEAR = 4'h0;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INIT    = 4'd1,
    S_SETTLE  = 4'd2,
    S_CLEAR   = 4'd3,
    S_MEASURE = 4'd4,
    S_DECIDE  = 4'd5,
    S_STEP    = 4'd6,
    S_NEXTQ   = 4'd7,
    S_DONE    = 4'd8,
    S_FAIL    = 4'd9
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_steps;
  logic          r_dir_set;
  logic [1:0]    r_dir_src;
  logic [1:0]    r_meas;
  logic          r_pre_wcmd;
  logic [3:0]    r_wd;
  logic          r_busy;
  logic          r_done;
  logic          r_fail;
  logic [1:0]    r_fail_code;
  logic [8:0]    r_dcm_ofs;
  logic [1:0]    r_quad;

  // Late (1) pulls the DCM back, early (2) pushes it forward.
  logic w_step_dec;
  assign w_step_dec = r_dir_set ? (r_dir_src == 2'd1) : (r_meas == 2'd1);

  assign pre_wcmd  = r_pre_wcmd;
  assign wd        = r_wd;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
  assign dcm_ofs   = r_dcm_ofs;
  assign quad      = r_quad;

  always_ff @(posedge sclk0) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_steps     <= 8'd0;
      r_dir_set   <= 1'b0;
      r_dir_src   <= 2'd0;
      r_meas      <= 2'd0;
      r_pre_wcmd  <= 1'b0;
      r_wd        <= c_CMD_CLEAR;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= 2'd0;
      r_dcm_ofs   <= 9'd0;
      r_quad      <= 2'd0;
    end else begin
      r_pre_wcmd <= 1'b0;
      r_wd       <= c_CMD_CLEAR;
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            r_state     <= S_INIT;
            r_pre_wcmd  <= 1'b1;
            r_wd        <= c_CMD_RESET;
            r_dcm_ofs   <= 9'd0;
            r_quad      <= 2'd0;
            r_steps     <= 8'd0;
            r_dir_set   <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= 2'd0;
            r_busy      <= 1'b1;
          end
        end
        S_INIT, S_STEP: begin
          r_state <= S_SETTLE;
          r_cnt   <= CW'(1);
        end
        S_SETTLE: begin
          if (r_cnt == c_SETTLE_LAST) begin
            r_state    <= S_CLEAR;
            r_pre_wcmd <= 1'b1;
            r_wd       <= c_CMD_CLEAR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CLEAR: begin
          r_state <= S_MEASURE;
          r_cnt   <= CW'(1);
        end
        S_MEASURE: begin
          // r_cnt equals the number of cycles elapsed since the clear strobe.
          if ((r_cnt >= c_MEAS_FIRST) && (ph_err != 2'd0)) begin
            r_meas  <= ph_err;
            r_state <= S_DECIDE;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            r_state     <= S_FAIL;
            r_fail      <= 1'b1;
            r_fail_code <= 2'd1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DECIDE: begin
          if ((r_meas == 2'd3) || (r_dir_set && (r_meas != r_dir_src))) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_dir_set && (r_steps == c_MAX_STEPS)) begin
            r_state <= S_NEXTQ;
            if (r_quad != 2'd3) begin
              r_pre_wcmd <= 1'b1;
              r_wd       <= c_CMD_NEXTQ;
              r_quad     <= r_quad + 2'd1;
              r_dcm_ofs  <= 9'd0;
              r_steps    <= 8'd0;
              r_dir_set  <= 1'b0;
            end
          end else begin
            if (!r_dir_set) begin
              r_dir_set <= 1'b1;
              r_dir_src <= r_meas;
            end
            r_state    <= S_STEP;
            r_pre_wcmd <= 1'b1;
            r_wd       <= w_step_dec ? c_CMD_DEC : c_CMD_INC;
            r_dcm_ofs  <= w_step_dec ? (r_dcm_ofs - 9'd1) : (r_dcm_ofs + 9'd1);
            r_steps    <= r_steps + 8'd1;
          end
        end
        S_NEXTQ: begin
          // No strobe was issued on entry only when the last quadrant was exhausted.
          if (r_pre_wcmd) begin
            r_state <= S_SETTLE;
            r_cnt   <= CW'(1);
          end else begin
            r_state     <= S_FAIL;
            r_fail      <= 1'b1;
            r_fail_code <= 2'd2;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_phase_cal.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sdram_phase_cal: directed bench with a phase detector/DCM model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sdram_phase_cal;

  logic       clk;
  logic       rst;
  logic       start;
  wire  [1:0] ph_err;
  logic       pre_wcmd;
  logic [3:0] wd;
  logic       busy;
  logic       done;
  logic       fail;
  logic [1:0] fail_code;
  logic [8:0] dcm_ofs;
  logic [1:0] quad;

  sdram_phase_cal #(
    .MAX_STEPS  (8),
    .SETTLE_CYC (16),
    .MEAS_CYC   (64),
    .TIMEOUT_CYC(4096)
  ) dut (
    .sclk0    (clk),
    .rst      (rst),
    .start    (start),
    .ph_err   (ph_err),
    .pre_wcmd (pre_wcmd),
    .wd       (wd),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .fail_code(fail_code),
    .dcm_ofs  (dcm_ofs),
    .quad     (quad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  // Detector/DCM model state, advanced by the commands the DUT issues.
  int cyc = 0;
  int m_ofs, m_q, q_max;
  int n_f, n_7, n_1, n_2, n_0, n_bad, n_junk;
  int first_clr, fail_cyc, last_cmd, min_gap;

  function automatic logic [1:0] f_model(input int md, input int ofs, input int q);
    case (md)
      0:       return 2'd3;
      1:       return (ofs < 5) ? 2'd2 : 2'd1;
      2:       return ((q == 1) && (ofs == -3)) ? 2'd3 : 2'd1;
      3:       return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  assign ph_err = f_model(mode, m_ofs, m_q);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      n_f <= 0; n_7 <= 0; n_1 <= 0; n_2 <= 0; n_0 <= 0; n_bad <= 0; n_junk <= 0;
      m_ofs <= 0; m_q <= 0; q_max <= 0;
      first_clr <= -1; fail_cyc <= -1; last_cmd <= -1; min_gap <= 1000000;
    end else begin
      if (pre_wcmd) begin
        if ((last_cmd >= 0) && ((cyc - last_cmd) < min_gap)) min_gap <= cyc - last_cmd;
        last_cmd <= cyc;
        case (wd)
          4'hF: begin n_f <= n_f + 1; m_ofs <= 0; m_q <= 0; end
          4'h7: begin n_7 <= n_7 + 1; m_ofs <= 0; m_q <= m_q + 1; end
          4'h1: begin n_1 <= n_1 + 1; m_ofs <= m_ofs + 1; end
          4'h2: begin n_2 <= n_2 + 1; m_ofs <= m_ofs - 1; end
          4'h0: begin n_0 <= n_0 + 1; if (first_clr < 0) first_clr <= cyc; end
          default: n_bad <= n_bad + 1;
        endcase
      end else if (wd != 4'h0) begin
        n_junk <= n_junk + 1;
      end
      if (int'(quad) > q_max) q_max <= int'(quad);
      if (fail && (fail_cyc < 0)) fail_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n = 0;
    while (!(done || fail) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_terminated"}, {31'd0, done | fail}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    do_reset;
    chk("reset_outputs", {13'd0, pre_wcmd, wd, busy, done, fail, fail_code, dcm_ofs, quad}, 32'd0);

    // Already aligned at default phase.
    mode = 0;
    pulse_start;
    chk("t1_strobe_latency", {31'd0, pre_wcmd}, 32'd1);
    chk("t1_reset_cmd", {28'd0, wd}, 32'hF);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_start_while_busy_no_strobe", {31'd0, pre_wcmd}, 32'd0);
    wait_end(2000, "t1");
    chk("t1_done", {30'd0, done, fail}, 32'd2);
    chk("t1_ofs_quad", {21'd0, dcm_ofs, quad}, 32'd0);
    chk("t1_cmd_counts", n_f * 256 + n_0 * 16 + n_1 + n_2, 32'h111 - 32'h1);
    chk("t1_min_gap", min_gap, 32'd17);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);

    // Early below offset 5, late at and above it.
    do_reset;
    mode = 1;
    pulse_start;
    wait_end(5000, "t2");
    chk("t2_done", {30'd0, done, fail}, 32'd2);
    chk("t2_ofs", {23'd0, dcm_ofs}, 32'h005);
    chk("t2_inc_count", n_1, 32'd5);
    chk("t2_dec_count", n_2, 32'd0);
    chk("t2_quad", {30'd0, quad}, 32'd0);

    // Late through quadrant 0, mixed at quadrant 1 offset -3.
    do_reset;
    mode = 2;
    pulse_start;
    wait_end(10000, "t3");
    chk("t3_done", {30'd0, done, fail}, 32'd2);
    chk("t3_quad", {30'd0, quad}, 32'd1);
    chk("t3_ofs", {23'd0, dcm_ofs}, 32'h1FD);
    chk("t3_dec_count", n_2, 32'd11);
    chk("t3_nextq_count", n_7, 32'd1);
    chk("t3_inc_count", n_1, 32'd0);

    // No read data at all.
    do_reset;
    mode = 3;
    pulse_start;
    wait_end(10000, "t4");
    chk("t4_fail_code", {29'd0, fail, fail_code}, 32'h5);
    chk("t4_timeout_latency", fail_cyc - first_clr, 32'd4096);
    chk("t4_done_busy", {30'd0, done, busy}, 32'd0);
    chk("t4_no_junk_cmds", n_bad + n_junk, 32'd0);

    // Restart straight from FAIL; late everywhere exhausts all quadrants.
    mode = 4;
    pulse_start;
    chk("t5_restart_clears_fail", {29'd0, fail, fail_code}, 32'd0);
    chk("t5_restart_strobe", {27'd0, pre_wcmd, wd}, 32'h1F);
    wait_end(20000, "t5");
    chk("t5_fail_code", {29'd0, fail, fail_code}, 32'h6);
    chk("t5_quad", {30'd0, quad}, 32'd3);
    chk("t5_nextq_count", n_7, 32'd3);
    chk("t5_quad_max", q_max, 32'd3);
    chk("t5_dec_count", n_2, 32'd32);
    chk("t5_ofs", {23'd0, dcm_ofs}, 32'h1F8);
    chk("t5_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a step command.
    do_reset;
    mode = 1;
    pulse_start;
    begin
      int n = 0;
      while (!(pre_wcmd && (wd == 4'h1)) && (n < 2000)) begin
        @(negedge clk);
        n++;
      end
      chk("t6_step_seen", {30'd0, pre_wcmd, dcm_ofs[0]}, 32'd3);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outputs", {13'd0, pre_wcmd, wd, busy, done, fail, fail_code, dcm_ofs, quad}, 32'd0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("t6_no_cmd_after_rst", n_f + n_7 + n_1 + n_2 + n_0, 32'd0);
    chk("t6_idle", {29'd0, busy, done, fail}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
